// File: rtl/icache.sv
// Direct-mapped instruction cache with 64-bit lines (two instructions per line).
// Hits return the instruction combinationally. Misses stall the pipeline and refill one line over a ready handshake.
module icache #(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              req,
  input  logic              flush,
  output logic [31:0]       inst,
  output logic              inst_valid,
  output logic              miss_stall,
  output logic [ADDR_W-1:0] m_rd_address,
  output logic              mrden,
  input  logic [63:0]       data_in_mem,
  input  logic              mem_ready,
  output logic [31:0]       miss_count
);

  localparam int unsigned TAG_LSB   = 3 + INDEX_BITS;
  localparam int unsigned TAG_W     = ADDR_W - TAG_LSB;
  localparam int unsigned NUM_LINES = 1 << INDEX_BITS;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REFILL = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;

  logic [1:0]            state_q;
  logic [1:0]            state_d;
  logic [NUM_LINES-1:0]  valid_q;
  logic [TAG_W-1:0]      tag_mem  [NUM_LINES];
  logic [63:0]           data_mem [NUM_LINES];

  logic [INDEX_BITS-1:0] pc_index;
  logic [TAG_W-1:0]      pc_tag;
  logic [INDEX_BITS-1:0] fill_index;
  logic [TAG_W-1:0]      fill_tag;
  logic [63:0]           rd_line;
  logic                  lookup_hit;
  logic                  take_miss;
  logic                  fill_we;
  logic [1:0]            unused_pc_bits;

  assign pc_index       = pc[TAG_LSB-1:3];
  assign pc_tag         = pc[ADDR_W-1:TAG_LSB];
  assign fill_index     = m_rd_address[TAG_LSB-1:3];
  assign fill_tag       = m_rd_address[ADDR_W-1:TAG_LSB];
  assign rd_line        = data_mem[pc_index];
  assign lookup_hit     = valid_q[pc_index] && (tag_mem[pc_index] == pc_tag);
  assign unused_pc_bits = pc[1:0];

  // Next-state and fetch-side outputs; reset forces the fetch outputs quiet.
  always_comb begin
    state_d    = state_q;
    inst       = 32'd0;
    inst_valid = 1'b0;
    miss_stall = 1'b0;
    take_miss  = 1'b0;
    fill_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && !flush) begin
          if (lookup_hit) begin
            inst_valid = 1'b1;
            inst       = pc[2] ? rd_line[63:32] : rd_line[31:0];
          end else begin
            miss_stall = 1'b1;
            take_miss  = 1'b1;
            state_d    = REFILL;
          end
        end
      end
      REFILL: begin
        miss_stall = 1'b1;
        if (mem_ready) begin
          fill_we = !flush;
          state_d = IDLE;
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        miss_stall = 1'b1;
        if (mem_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!rst) begin
      inst       = 32'd0;
      inst_valid = 1'b0;
      miss_stall = 1'b0;
      take_miss  = 1'b0;
      fill_we    = 1'b0;
    end
  end

  // Controller state, request port and miss counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      mrden        <= 1'b0;
      m_rd_address <= '0;
      miss_count   <= 32'd0;
    end else begin
      state_q <= state_d;
      mrden   <= (state_d != IDLE);
      if (take_miss) begin
        m_rd_address <= {pc[ADDR_W-1:3], 3'b000};
        miss_count   <= miss_count + 32'd1;
      end
    end
  end

  // Valid bits: flush clears everything and overrides a same-cycle fill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (fill_we) begin
      valid_q[fill_index] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; validity is tracked separately.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_mem[fill_index] <= data_in_mem;
      tag_mem[fill_index]  <= fill_tag;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Bench for icache: directed scenarios plus randomized fetch/flush traffic against a line-level cache model.
module tb_icache;

  localparam int unsigned IB = 6;
  localparam int unsigned NL = 1 << IB;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc = 32'd0;
  logic        req = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] inst;
  logic        inst_valid;
  logic        miss_stall;
  logic [31:0] m_rd_address;
  logic        mrden;
  logic [63:0] data_in_mem = 64'd0;
  logic        mem_ready = 1'b0;
  logic [31:0] miss_count;

  int n_cmp = 0;
  int n_err = 0;
  int forced_wait = -1;

  // Model: which line address each index holds, plus the single outstanding refill.
  logic        m_valid [NL];
  logic [28:0] m_line  [NL];
  logic        m_busy = 1'b0;
  logic        m_discard = 1'b0;
  logic [31:0] m_addr = 32'd0;
  logic [31:0] m_count = 32'd0;

  icache #(.INDEX_BITS(IB), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .pc(pc), .req(req), .flush(flush),
    .inst(inst), .inst_valid(inst_valid), .miss_stall(miss_stall),
    .m_rd_address(m_rd_address), .mrden(mrden),
    .data_in_mem(data_in_mem), .mem_ready(mem_ready), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mem_line(input logic [31:0] a);
    if (a[31:3] == 29'd0) return 64'h00500093_00000013;
    return {a ^ 32'hDEADBEEF, a ^ 32'h13579BDF};
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [63:0] l;
    l = mem_line({a[31:3], 3'b000});
    return a[2] ? l[63:32] : l[31:0];
  endfunction

  function automatic logic model_hit(input logic [31:0] a);
    return m_valid[a[IB+2:3]] && (m_line[a[IB+2:3]] == a[31:3]);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory: answers each request after a chosen or random delay.
  initial begin : responder
    int  left;
    logic seen;
    left = 0;
    seen = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        mem_ready = 1'b0;
        seen = 1'b0;
      end else if (mem_ready) begin
        mem_ready = 1'b0;
        seen = 1'b0;
      end else if (mrden) begin
        if (!seen) begin
          seen = 1'b1;
          left = (forced_wait >= 0) ? forced_wait : int'($urandom_range(0, 3));
        end
        if (left == 0) begin
          mem_ready   = 1'b1;
          data_in_mem = mem_line(m_rd_address);
        end else begin
          left--;
        end
      end
    end
  end

  // Model update on each clock edge, cleared by reset.
  initial begin : model
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_busy = 1'b0;
        m_discard = 1'b0;
        m_count = 32'd0;
        m_addr = 32'd0;
        for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
      end else begin
        if (m_busy) begin
          if (mem_ready) begin
            m_busy = 1'b0;
            if (!m_discard && !flush) begin
              m_valid[m_addr[IB+2:3]] = 1'b1;
              m_line[m_addr[IB+2:3]]  = m_addr[31:3];
            end
          end else if (flush) begin
            m_discard = 1'b1;
          end
        end else if (req && !flush && !model_hit(pc)) begin
          m_busy = 1'b1;
          m_discard = 1'b0;
          m_addr = {pc[31:3], 3'b000};
          m_count = m_count + 32'd1;
        end
        if (flush) begin
          for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  initial begin : compare
    logic        e_valid;
    logic        e_stall;
    logic        e_mrden;
    logic [31:0] e_inst;
    forever begin
      @(negedge clk);
      e_valid = 1'b0;
      e_stall = 1'b0;
      e_mrden = 1'b0;
      e_inst  = 32'd0;
      if (rst) begin
        if (m_busy) begin
          e_stall = 1'b1;
          e_mrden = 1'b1;
        end else if (req && !flush) begin
          if (model_hit(pc)) begin
            e_valid = 1'b1;
            e_inst  = mem_word(pc);
          end else begin
            e_stall = 1'b1;
          end
        end
      end
      check("cyc_inst_valid", 64'(inst_valid), 64'(e_valid));
      check("cyc_miss_stall", 64'(miss_stall), 64'(e_stall));
      check("cyc_mrden", 64'(mrden), 64'(e_mrden));
      check("cyc_miss_count", 64'(miss_count), 64'(m_count));
      if (e_valid || !rst || (!m_busy && !req)) check("cyc_inst", 64'(inst), 64'(e_inst));
      if (!rst) check("cyc_addr_reset", 64'(m_rd_address), 64'd0);
      else if (m_busy) check("cyc_addr", 64'(m_rd_address), 64'(m_addr));
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic finish_fill(output int n, output logic [31:0] addr);
    n = 0;
    addr = '1;
    while (miss_stall && n < 64) begin
      n++;
      if (mrden) addr = m_rd_address;
      step();
      #1;
    end
    check("fill_done", 64'(miss_stall), 64'd0);
  endtask

  task automatic fetch(input logic [31:0] a, output int n, output logic [31:0] addr);
    step();
    pc = a;
    req = 1'b1;
    flush = 1'b0;
    #1;
    finish_fill(n, addr);
  endtask

  initial begin : driver
    int          n;
    logic [31:0] ra;

    step();
    step();
    check("reset_miss_count", 64'(miss_count), 64'd0);
    check("reset_mrden", 64'(mrden), 64'd0);
    check("reset_stall", 64'(miss_stall), 64'd0);
    check("reset_inst_valid", 64'(inst_valid), 64'd0);
    check("reset_addr", 64'(m_rd_address), 64'd0);
    rst = 1'b1;

    // Cold miss at 0x0 with a three-cycle memory.
    forced_wait = 2;
    fetch(32'h0, n, ra);
    check("cold_stall_cycles", 64'(n), 64'd4);
    check("cold_addr", 64'(ra), 64'h0);
    check("cold_inst_valid", 64'(inst_valid), 64'd1);
    check("cold_inst", 64'(inst), 64'h00000013);
    check("cold_count", 64'(miss_count), 64'd1);

    fetch(32'h4, n, ra);
    check("hit_stalls", 64'(n), 64'd0);
    check("hit_inst", 64'(inst), 64'h00500093);
    check("hit_mrden", 64'(mrden), 64'd0);
    check("hit_count", 64'(miss_count), 64'd1);

    // Conflict at index 0.
    forced_wait = -1;
    fetch(32'h0, n, ra);
    check("conf_warm_hit", 64'(n), 64'd0);
    fetch(32'h200, n, ra);
    check("conf_miss", 64'(n > 0), 64'd1);
    check("conf_addr", 64'(ra), 64'h200);
    check("conf_inst", 64'(inst), 64'h135799DF);
    fetch(32'h0, n, ra);
    check("conf_back_miss", 64'(n > 0), 64'd1);
    check("conf_count", 64'(miss_count), 64'd3);
    check("conf_back_inst", 64'(inst), 64'h00000013);

    // Flush one cycle into a refill of 0x40.
    step();
    pc = 32'h40;
    req = 1'b1;
    forced_wait = 3;
    #1;
    check("fr_miss", 64'(miss_stall), 64'd1);
    step(); #1;
    check("fr_mrden_rise", 64'(mrden), 64'd1);
    step(); flush = 1'b1; #1;
    check("fr_flush_mrden", 64'(mrden), 64'd1);
    check("fr_flush_valid", 64'(inst_valid), 64'd0);
    step(); flush = 1'b0; #1;
    check("fr_drain_mrden", 64'(mrden), 64'd1);
    check("fr_drain_stall", 64'(miss_stall), 64'd1);
    step(); #1;
    check("fr_ready_mrden", 64'(mrden), 64'd1);
    forced_wait = -1;
    step(); #1;
    check("fr_idle_mrden", 64'(mrden), 64'd0);
    check("fr_refetch_miss", 64'(miss_stall), 64'd1);
    finish_fill(n, ra);
    check("fr_refetch_addr", 64'(ra), 64'h40);
    check("fr_inst", 64'(inst), 64'h13579B9F);
    check("fr_count", 64'(miss_count), 64'd5);

    // Flush while idle with a warm cache.
    fetch(32'h0, n, ra);
    fetch(32'h8, n, ra);
    fetch(32'h0, n, ra);
    check("fi_warm", 64'(n), 64'd0);
    step();
    flush = 1'b1;
    pc = 32'h8;
    #1;
    check("fi_pulse_valid", 64'(inst_valid), 64'd0);
    check("fi_pulse_stall", 64'(miss_stall), 64'd0);
    fetch(32'h0, n, ra);
    check("fi_miss0", 64'(n > 0), 64'd1);
    fetch(32'h8, n, ra);
    check("fi_miss8", 64'(n > 0), 64'd1);
    check("fi_count", 64'(miss_count), 64'd9);

    // Asynchronous reset in the middle of a refill.
    step();
    pc = 32'h100;
    req = 1'b1;
    forced_wait = 5;
    #1;
    check("ar_miss", 64'(miss_stall), 64'd1);
    step(); #1;
    check("ar_mrden", 64'(mrden), 64'd1);
    step(); #1;
    rst = 1'b0;
    #1;
    check("ar_mrden_drop", 64'(mrden), 64'd0);
    check("ar_stall_drop", 64'(miss_stall), 64'd0);
    check("ar_count", 64'(miss_count), 64'd0);
    step();
    rst = 1'b1;
    forced_wait = -1;
    #1;
    check("ar_refetch_miss", 64'(miss_stall), 64'd1);
    finish_fill(n, ra);
    check("ar_refetch_addr", 64'(ra), 64'h100);
    check("ar_refetch_count", 64'(miss_count), 64'd1);
    fetch(32'h0, n, ra);
    check("ar_old_line_miss", 64'(n > 0), 64'd1);

    // Randomized traffic; PC mostly held while stalled, as the pipeline would.
    for (int i = 0; i < 3000; i++) begin
      step();
      if (!miss_stall || $urandom_range(0, 7) == 0) begin
        pc  = {21'd0, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 15)), 3'($urandom_range(0, 7))};
        req = ($urandom_range(0, 9) != 0);
      end
      flush = ($urandom_range(0, 49) == 0);
    end

    step();
    req = 1'b0;
    flush = 1'b0;
    repeat (6) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped instruction cache between Reg_PC and Reg_D; replaces the flat instruction SRAM on the fetch path.
- Returns the 32-bit instruction at `pc` in the same cycle on a hit.
- On a miss it raises `miss_stall`, refills one 64-bit line (two instructions) from instruction memory over a ready handshake, then resumes.
- `miss_stall` is ORed into the pipeline `waiting` hold so PC and the pipeline registers freeze during refill.

Parameters:
- INDEX_BITS, 6, number of index bits; the cache holds 2^INDEX_BITS lines.
- ADDR_W, 32, fetch address width.
- TAG_W, ADDR_W-3-INDEX_BITS, tag width (23 at defaults).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-low.
- pc  input  ADDR_W  fetch address from Reg_PC.
- req  input  1  fetch request valid.
- flush  input  1  invalidate all lines (fence.i).
- inst  output  32  fetched instruction.
- inst_valid  output  1  `inst` is valid this cycle.
- miss_stall  output  1  hold PC and pipeline.
- m_rd_address  output  ADDR_W  line-aligned refill address.
- mrden  output  1  memory read request.
- data_in_mem  input  64  refill data.
- mem_ready  input  1  `data_in_mem` valid; completes the request.
- miss_count  output  32  number of misses taken, wraps at 2^32.

Behaviour:
- Address split:
  - `pc[1:0]` is ignored.
  - `pc[2]` selects the word: 0 gives line[31:0], 1 gives line[63:32].
  - index = `pc[3+INDEX_BITS-1:3]`.
  - tag = `pc[ADDR_W-1:3+INDEX_BITS]`.
- Storage: per line a valid bit, a TAG_W tag and 64 data bits. Array reads are combinational; writes happen on the clk edge.
- Reset (rst=0, asynchronous):
  - All valid bits clear; state IDLE; miss_count=0.
  - inst=0, inst_valid=0, miss_stall=0, mrden=0, m_rd_address=0.
  - Data and tag arrays need no reset.
- States are IDLE, REFILL and DRAIN.
- IDLE:
  - hit = req & valid[index] & (tag match) & !flush. On a hit: inst_valid=1 and inst=selected word, combinationally, with zero latency.
  - miss = req & !hit & !flush. On a miss: miss_stall=1 combinationally in the same cycle; next state REFILL; latch line address {pc[ADDR_W-1:3],3'b000}; miss_count+1.
  - req=0: inst_valid=0, miss_stall=0, inst=0.
- REFILL:
  - mrden=1, m_rd_address held at the latched line address, miss_stall=1, inst_valid=0.
  - On mem_ready=1: write data_in_mem into the line, write the latched tag, set valid; next state IDLE.
  - The next cycle is a hit, if PC is unchanged (guaranteed because the stall holds it).
  - Miss penalty = (1 + number of cycles until mem_ready) stall cycles.
- DRAIN:
  - Same outputs as REFILL, but on mem_ready the data is discarded, the line is not validated, and the next state is IDLE.
- Flush:
  - In any state, all valid bits clear at the next edge.
  - flush=1 forces inst_valid=0 that cycle.
  - Flush in IDLE: stay IDLE, no miss is counted.
  - Flush in REFILL without mem_ready: next state DRAIN.
  - Flush in REFILL with mem_ready in the same cycle: the clear wins and the line stays invalid; next state IDLE.
- Memory request rule: mrden, once asserted, stays high with a stable address until mem_ready. Only one request is outstanding at a time.
- Conflict miss: a new tag at the same index overwrites the line; there is no write-back (instruction memory is read-only).
- miss_count counts misses only; it wraps 0xFFFFFFFF to 0.
- Reset asserted mid-refill: aborts immediately to IDLE with mrden=0. Memory must tolerate an abandoned request.

Test Plan:
- Cold miss:
  - Stimulus: release reset, req=1, pc=0x0000_0000, memory returns 0x00500093_00000013 after 3 cycles.
  - Required: miss_stall high for 4 cycles, mrden high with m_rd_address=0; then inst_valid=1, inst=0x00000013, miss_count=1.
- Same-line hit:
  - Stimulus: after the cold miss, pc=0x4.
  - Required: inst=0x00500093 in the same cycle, no mrden, miss_count stays 1.
- Conflict:
  - Stimulus: with INDEX_BITS=6, fetch 0x0 then 0x200.
  - Required: second fetch misses and refills at m_rd_address=0x200; fetching 0x0 again misses; miss_count=3.
- Flush during refill:
  - Stimulus: miss on 0x40, assert flush one cycle after mrden rises, mem_ready 2 cycles later.
  - Required: state goes to DRAIN; the next fetch of 0x40 misses again; mrden never deasserts before mem_ready.
- Flush in IDLE:
  - Stimulus: cache warm with 0x0 and 0x8, pulse flush.
  - Required: inst_valid=0 during the pulse; both addresses then miss.
- Async reset mid-refill:
  - Stimulus: drop rst between clock edges while in REFILL.
  - Required: mrden=0 and miss_stall=0 immediately; fetch of the previous address misses.
